// File: rtl/video_mem_arbiter.sv
// Arbiter sharing a single-port synchronous video RAM between the vga fetch stage and the CPU.
// Video fetches always win a RAM slot and have a fixed 3-clock latency.
// A CPU access is latched into a one-deep pending register and issued on the next clock that
// has no video strobe. The CPU is held off with cpu_busy until the one-cycle cpu_ack.
// Every RAM control output is registered. Read data is captured by per-operation pipeline
// tags, so a CPU read and a video read issued on adjacent clocks each capture their own byte.
module video_mem_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // vga fetch side
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_overrun,
  // CPU bus side
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_busy,
  output logic              cpu_ack,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWrDone,
    StRd1,
    StRd2
  } state_e;

  state_e state_q, state_d;

  // One-deep pending CPU request
  logic              pend_valid_q, pend_valid_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_din_q, pend_din_d;

  // Video read tags: p1 = RAM reading, p2 = ram_dout holds the video byte
  logic              vid_p1_q, vid_p1_d;
  logic              vid_p2_q, vid_p2_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_overrun_q, vid_overrun_d;

  // CPU response registers
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic              cpu_ack_q, cpu_ack_d;

  // Registered RAM port
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;

  logic accept;
  logic issue;
  logic cpu_done;

  // Decode the accept, issue and completion conditions for this cycle
  always_comb begin
    accept   = cpu_cs && !cpu_busy_q && !pend_valid_q && (state_q == StIdle);
    // A video strobe claims this clock's RAM slot, so CPU issue slips by one clock
    issue    = pend_valid_q && !vid_req && (state_q == StWait);
    cpu_done = (state_q == StWrDone) || (state_q == StRd2);
  end

  // CPU access FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StWait;
      end
      StWait: begin
        if (issue) state_d = pend_we_q ? StWrDone : StRd1;
      end
      StWrDone: state_d = StIdle;
      StRd1:    state_d = StRd2;
      StRd2:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pending register: load on accept, release on issue
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_din_d   = pend_din_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_we_d    = cpu_we;
      pend_addr_d  = cpu_addr;
      pend_din_d   = cpu_din;
    end else if (issue) begin
      pend_valid_d = 1'b0;
    end
  end

  // RAM port: video strobe first, then the pending CPU request; write enable lasts one clock
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    if (vid_req) begin
      ram_addr_d = vid_addr;
    end else if (issue) begin
      ram_addr_d = pend_addr_q;
      ram_din_d  = pend_din_q;
      ram_we_d   = pend_we_q;
    end
  end

  // Video pipeline tags, capture of the fetched byte and sticky overrun detection
  always_comb begin
    vid_p1_d      = vid_req;
    vid_p2_d      = vid_p1_q;
    vid_data_d    = vid_data_q;
    vid_overrun_d = vid_overrun_q;
    if (vid_p2_q) vid_data_d = ram_dout;
    // A strobe while an earlier fetch is still in flight is served but flagged
    if (vid_req && (vid_p1_q || vid_p2_q)) vid_overrun_d = 1'b1;
  end

  // CPU handshake: busy from the clock after accept until the ack cycle
  always_comb begin
    cpu_dout_d = cpu_dout_q;
    cpu_busy_d = cpu_busy_q;
    cpu_ack_d  = cpu_done;
    if (state_q == StRd2) cpu_dout_d = ram_dout;
    if (accept) begin
      cpu_busy_d = 1'b1;
    end else if (cpu_done) begin
      cpu_busy_d = 1'b0;
    end
  end

  // FSM and pending request state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_din_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_din_q   <= pend_din_d;
    end
  end

  // Video pipeline and RAM port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_p1_q      <= 1'b0;
      vid_p2_q      <= 1'b0;
      vid_data_q    <= '0;
      vid_overrun_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      vid_p1_q      <= vid_p1_d;
      vid_p2_q      <= vid_p2_d;
      vid_data_q    <= vid_data_d;
      vid_overrun_q <= vid_overrun_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
    end
  end

  // CPU response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_dout_q <= '0;
      cpu_busy_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
    end else begin
      cpu_dout_q <= cpu_dout_d;
      cpu_busy_q <= cpu_busy_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  assign vid_data    = vid_data_q;
  assign vid_overrun = vid_overrun_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_busy    = cpu_busy_q;
  assign cpu_ack     = cpu_ack_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;

  // A CPU write never shares a clock with a video read in progress
  a_we_not_in_video_slot: assert property (@(posedge clk) disable iff (!reset)
    !(ram_we_q && vid_p1_q));

  // The ack cycle is never also reported busy
  a_ack_not_busy: assert property (@(posedge clk) disable iff (!reset)
    cpu_ack_q |-> !cpu_busy_q);

endmodule
